// File: rtl/module_ula_74181.sv
// module_ula_74181 -- registered 4-bit ALU with 74181 function set.
// Arithmetic mode adds the X/Y terms with carry-in and wraps modulo 16.
// Logic mode returns the XNOR of the X/Y terms.
// All outputs are registered with one cycle of latency.
// t=1 freezes the outputs. rst has priority over t.
// Optional feature: define ULA_PG_OUT_EN to add registered
// propagate (p) and generate (g) outputs.
module module_ula_74181 (
   input  logic       clk,
   input  logic       rst,
   input  logic       t,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       c_in,
   output logic [3:0] f,
   output logic       a_eq_b,
   output logic       c_out
`ifdef ULA_PG_OUT_EN
   ,
   output logic       p,
   output logic       g
`endif
);

   // Selects whose arithmetic meaning is a subtraction report borrow
   // (inverted carry) rather than carry.
   function automatic logic is_sub_sel(input logic [3:0] sel);
      return (sel == 4'b0011) || (sel == 4'b0110) || (sel == 4'b0111) ||
             (sel == 4'b1011) || (sel == 4'b1111);
   endfunction

   logic [3:0] x_term;
   logic [3:0] y_term;
   logic [4:0] sum_r;
   logic [4:0] sum_xy;

   logic [3:0] f_d, f_q;
   logic       a_eq_b_d, a_eq_b_q;
   logic       c_out_d, c_out_q;
`ifdef ULA_PG_OUT_EN
   logic       p_d, p_q;
   logic       g_d, g_q;
`endif

   // Operand shaping and the two sums: with carry-in for the result,
   // without it for propagate/generate.
   always_comb begin
      x_term = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
      y_term = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
      sum_xy = {1'b0, x_term} + {1'b0, y_term};
      sum_r  = sum_xy + {4'b0000, c_in};
   end

   // Next-state selection; t=1 keeps the current register contents.
   always_comb begin
      f_d      = f_q;
      a_eq_b_d = a_eq_b_q;
      c_out_d  = c_out_q;
`ifdef ULA_PG_OUT_EN
      p_d      = p_q;
      g_d      = g_q;
`endif
      if (!t) begin
         if (!m) begin
            f_d     = sum_r[3:0];
            c_out_d = is_sub_sel(s) ? ~sum_r[4] : sum_r[4];
`ifdef ULA_PG_OUT_EN
            p_d     = (sum_xy[3:0] == 4'b1111);
            g_d     = sum_xy[4];
`endif
         end else begin
            f_d     = ~(x_term ^ y_term);
            c_out_d = 1'b0;
`ifdef ULA_PG_OUT_EN
            p_d     = 1'b0;
            g_d     = 1'b0;
`endif
         end
         a_eq_b_d = (f_d == 4'b1111);
      end
   end

   // Output registers with synchronous reset taking priority over hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_q      <= 4'b0000;
         a_eq_b_q <= 1'b0;
         c_out_q  <= 1'b0;
`ifdef ULA_PG_OUT_EN
         p_q      <= 1'b0;
         g_q      <= 1'b0;
`endif
      end else begin
         f_q      <= f_d;
         a_eq_b_q <= a_eq_b_d;
         c_out_q  <= c_out_d;
`ifdef ULA_PG_OUT_EN
         p_q      <= p_d;
         g_q      <= g_d;
`endif
      end
   end

   assign f      = f_q;
   assign a_eq_b = a_eq_b_q;
   assign c_out  = c_out_q;
`ifdef ULA_PG_OUT_EN
   assign p      = p_q;
   assign g      = g_q;
`endif

endmodule

// File: tb/tb_module_ula_74181.sv
// Scoreboard bench for module_ula_74181.
// The driver applies directed vectors on the falling edge.
// It queues the hand-computed response for each vector.
// The monitor pops one entry per rising edge and compares it with the outputs.
module tb_module_ula_74181;

   logic       clk = 1'b0;
   logic       rst, t, m, c_in;
   logic [3:0] a, b, s;
   logic [3:0] f;
   logic       a_eq_b, c_out;
`ifdef ULA_PG_OUT_EN
   logic       p, g;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      name;
      logic [3:0] f;
      logic       a_eq_b;
      logic       c_out;
      logic       chk_pg;
      logic       p;
      logic       g;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   module_ula_74181 dut (
      .clk    (clk),
      .rst    (rst),
      .t      (t),
      .a      (a),
      .b      (b),
      .s      (s),
      .m      (m),
      .c_in   (c_in),
      .f      (f),
      .a_eq_b (a_eq_b),
      .c_out  (c_out)
`ifdef ULA_PG_OUT_EN
      ,
      .p      (p),
      .g      (g)
`endif
   );

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Drive one vector and queue its expected registered response.
   task automatic op(input string nm, input logic r, input logic tt, input logic mm,
                     input logic [3:0] ss, input logic [3:0] aa, input logic [3:0] bb,
                     input logic cc, input logic [3:0] ef, input logic eq, input logic ec,
                     input logic cpg, input logic ep, input logic eg);
      exp_t e;
      @(negedge clk);
      rst = r; t = tt; m = mm; s = ss; a = aa; b = bb; c_in = cc;
      e.name = nm; e.f = ef; e.a_eq_b = eq; e.c_out = ec;
      e.chk_pg = cpg; e.p = ep; e.g = eg;
      sb.push_back(e);
   endtask

   // Monitor: the DUT answers every cycle, so one entry is due per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.name, ".f"}, f, e.f);
            chk({e.name, ".a_eq_b"}, {3'b000, a_eq_b}, {3'b000, e.a_eq_b});
            chk({e.name, ".c_out"}, {3'b000, c_out}, {3'b000, e.c_out});
`ifdef ULA_PG_OUT_EN
            if (e.chk_pg) begin
               chk({e.name, ".p"}, {3'b000, p}, {3'b000, e.p});
               chk({e.name, ".g"}, {3'b000, g}, {3'b000, e.g});
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Fixed operand pair for the logic sweep and its expected results.
   logic [3:0] lexp [16] = '{4'b1010, 4'b1000, 4'b0010, 4'b0000, 4'b1110, 4'b1100,
                             4'b0110, 4'b0100, 4'b1011, 4'b1001, 4'b0011, 4'b0001,
                             4'b1111, 4'b1101, 4'b0111, 4'b0101};

   initial begin
      rst = 1'b1; t = 1'b0; m = 1'b0; s = 4'h0; a = 4'h0; b = 4'h0; c_in = 1'b0;
      //  name        rst t  m  s      a      b      cin  f      eq ec  pg p  g
      op("reset",     1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0);
      op("post_rst",  0, 0, 0, 4'h0, 4'hF, 4'h0, 1, 4'h0, 0, 1, 1, 1, 0);
      op("sub_3m1",   0, 0, 0, 4'h6, 4'h3, 4'h1, 0, 4'h1, 0, 0, 0, 0, 0);
      op("sub_3m4",   0, 0, 0, 4'h6, 4'h3, 4'h4, 0, 4'hE, 0, 1, 0, 0, 0);
      op("sub_0m0",   0, 0, 0, 4'h6, 4'h0, 4'h0, 0, 4'hF, 1, 1, 0, 0, 0);
      op("sub_0m0c",  0, 0, 0, 4'h6, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0);
      op("add_3p1c",  0, 0, 0, 4'h9, 4'h3, 4'h1, 1, 4'h5, 0, 0, 0, 0, 0);
      op("s4_Fp0c",   0, 0, 0, 4'h4, 4'hF, 4'h0, 1, 4'hF, 1, 1, 0, 0, 0);
      op("sA_wrap",   0, 0, 0, 4'hA, 4'h1, 4'h0, 1, 4'h0, 0, 1, 0, 0, 0);
      op("sF_dec",    0, 0, 0, 4'hF, 4'h3, 4'h0, 0, 4'h2, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] sel;
         sel = 4'(i);
         op("logic", 0, 0, 1, sel, 4'b0101, 4'b0011, sel[0], lexp[i],
            (lexp[i] == 4'hF), 0, 1, 0, 0);
      end
      op("pre_hold",  0, 0, 1, 4'hC, 4'h5, 4'h3, 0, 4'hF, 1, 0, 1, 0, 0);
      op("hold1",     0, 1, 0, 4'h9, 4'h3, 4'h1, 1, 4'hF, 1, 0, 0, 0, 0);
      op("hold2",     0, 1, 0, 4'h6, 4'h3, 4'h4, 0, 4'hF, 1, 0, 0, 0, 0);
      op("hold3",     0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 4'hF, 1, 0, 0, 0, 0);
      op("release",   0, 0, 0, 4'h9, 4'h3, 4'h1, 1, 4'h5, 0, 0, 0, 0, 0);
      op("rst_over_t",1, 1, 0, 4'h4, 4'hF, 4'h0, 1, 4'h0, 0, 0, 1, 0, 0);
      op("rst_exit",  0, 0, 0, 4'h4, 4'hF, 4'h0, 1, 4'hF, 1, 1, 0, 0, 0);
      op("pg_prop",   0, 0, 0, 4'h9, 4'h5, 4'hA, 0, 4'hF, 1, 0, 1, 1, 0);
      op("pg_gen",    0, 0, 0, 4'h9, 4'h8, 4'h8, 0, 4'h0, 0, 1, 1, 0, 1);
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/module_ula_74181.md
MODULE_ULA_74181 -- requirements
Module: module_ula_74181

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on this edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 t  input  1  hold: 1 = output registers keep their value; 0 = normal update.
REQ-005 a  input  4  operand A, unsigned.
REQ-006 b  input  4  operand B, unsigned.
REQ-007 s  input  4  function select.
REQ-008 m  input  1  mode: 0 = arithmetic, 1 = logic.
REQ-009 c_in  input  1  carry in, active-high (1 adds one).
REQ-010 f  output  4  registered result.
REQ-011 a_eq_b  output  1  registered; 1 when the result is 4'b1111.
REQ-012 c_out  output  1  registered carry/borrow out, active-high.

Function
REQ-013 The block SHALL form X = a | (b & {4{s[0]}}) | (~b & {4{s[1]}}).
REQ-014 The block SHALL form Y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}).
REQ-015 Arithmetic mode (m=0) SHALL compute the 5-bit sum R = X + Y + c_in and take f_next = R[3:0].
REQ-016 The arithmetic set SHALL be, for s=0..15, each plus c_in: A; A|B; A|~B; minus1; A+(A&~B); (A|B)+(A&~B); A-B-1; (A&~B)-1; A+(A&B); A+B; (A|~B)+(A&B); (A&B)-1; A+A; (A|B)+A; (A|~B)+A; A-1.
REQ-017 Subtract-class selects are s in {0011,0110,0111,1011,1111}.
REQ-018 For subtract-class selects, c_out_next SHALL be ~R[4] (borrow); for all other selects it SHALL be R[4].
REQ-019 Logic mode (m=1) SHALL compute f_next = ~(X ^ Y), with c_in ignored.
REQ-020 The logic set SHALL be, for s=0..15: ~A; ~(A|B); ~A&B; 0000; ~(A&B); ~B; A^B; A&~B; ~A|B; ~(A^B); B; A&B; 1111; A|~B; A|B; A.
REQ-021 In logic mode c_out_next SHALL be 0.
REQ-022 a_eq_b_next SHALL be (f_next == 4'b1111) in both modes.
REQ-023 Latency SHALL be 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-024 There SHALL be no handshake; a new operation is accepted every cycle.
REQ-025 When t=1 and rst=0, f, a_eq_b, c_out (and p, g if present) SHALL hold their values.
REQ-026 Arithmetic SHALL wrap modulo 16, with the overflow reported only via c_out.

Reset
REQ-027 When rst=1 at a clock edge, the outputs SHALL be f=0000, a_eq_b=0, c_out=0 (and p=0, g=0 if present).
REQ-028 rst SHALL take priority over t.
REQ-029 The first edge with rst=0 SHALL load normally, so reset mid-operation discards the in-flight result.

Configuration
REQ-030 When the macro ULA_PG_OUT_EN is defined, the module SHALL add registered outputs p (1 bit) and g (1 bit).
REQ-031 In arithmetic mode, p_next SHALL be 1 iff X+Y == 4'b1111, and g_next SHALL be 1 iff X+Y >= 16, both independent of c_in.
REQ-032 In logic mode, p_next and g_next SHALL be 0.
REQ-033 Without ULA_PG_OUT_EN, ports p and g SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset: rst=1 for one edge -> f=0000, a_eq_b=0, c_out=0; then m=0, s=0000, a=1111, c_in=1, t=0 -> next cycle f=0000, c_out=1.
REQ-035 Subtract: m=0, s=0110 with (a=3, b=1, c_in=0) -> f=0001, c_out=0; (a=3, b=4, c_in=0) -> f=1110, c_out=1; (a=0, b=0, c_in=0) -> f=1111, c_out=1, a_eq_b=1; (a=0, b=0, c_in=1) -> f=0000, c_out=0.
REQ-036 Add family: m=0 with (s=1001, a=3, b=1, c_in=1) -> f=0101, c_out=0; (s=0100, a=F, b=0, c_in=1) -> f=1111, c_out=1; (s=1010, a=1, b=0, c_in=1) -> f=0000, c_out=1; (s=1111, a=3, c_in=0) -> f=0010, c_out=0.
REQ-037 Logic sweep: m=1, a=0101, b=0011, s=0..15 -> f = 1010, 1000, 0010, 0000, 1110, 1100, 0110, 0100, 1011, 1001, 0011, 0001, 1111, 1101, 0111, 0101, with c_out=0 throughout.
REQ-038 Hold: t=1 for 3 cycles while the inputs change -> the outputs stay frozen; t=0 -> the outputs update on the next edge.
REQ-039 With ULA_PG_OUT_EN defined: m=0, s=1001, a=5, b=A -> p=1, g=0; a=8, b=8 -> p=0, g=1.
